// File: rtl/axi_wr_scheduler_pkg.sv
// Shared definitions for the AXI write-side masters: scheduler states and burst defaults.
package axi_wr_scheduler_pkg;

   localparam int unsigned WBURST_LEN_DEF = 8;
   localparam int unsigned COL_BITS_DEF   = 10;
   localparam int unsigned BURST_W        = 9;   // holds 1..256 beats

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/axi_wr_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the port that did not win last.
module rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       en,
   output logic       g,
   output logic       valid
);

   logic last_grant;

   always_comb begin
      valid = en & (|req);
      g     = (req == 2'b11) ? ~last_grant : req[1];
   end

   always_ff @(posedge clk) begin
      if (!rstn)      last_grant <= 1'b1;
      else if (valid) last_grant <= g;
   end

endmodule

// File: rtl/axi_wr_scheduler.sv
// Two-port write scheduler: splits long requests into row-safe AXI bursts for the write master.
module axi_wr_scheduler
   import axi_wr_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 27,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned COL_BITS   = COL_BITS_DEF,
   parameter int unsigned WBURST_LEN = WBURST_LEN_DEF,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init_end,
   input  logic [1:0]            req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [LEN_WIDTH-1:0]  req_beats0,
   input  logic [LEN_WIDTH-1:0]  req_beats1,
   output logic [1:0]            req_ready,
   input  logic [DATA_WIDTH-1:0] req_data0,
   input  logic [DATA_WIDTH-1:0] req_data1,
   output logic [1:0]            req_data_en,
   output logic [1:0]            req_done,
   output logic                  wm_trig,
   output logic [ADDR_WIDTH-1:0] wm_addr,
   output logic [7:0]            wm_len,
   output logic [DATA_WIDTH-1:0] wm_data,
   input  logic                  wm_ready,
   input  logic                  wm_data_en,
   input  logic                  wm_done
);

   localparam int unsigned CW0 = (LEN_WIDTH > COL_BITS + 1) ? LEN_WIDTH : COL_BITS + 1;
   localparam int unsigned CW  = (CW0 > BURST_W) ? CW0 : BURST_W;

   state_t                state, next;
   logic                  gnt, next_gnt;
   logic                  arb_g, arb_valid;
   logic [ADDR_WIDTH-1:0] cur_addr, sel_addr;
   logic [LEN_WIDTH-1:0]  remain, sel_beats;
   logic [BURST_W-1:0]    burst, burst_c;
   logic [COL_BITS:0]     room;
   logic [CW-1:0]         bmin;

   rr_arb2 u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .req   (req_valid),
      .en    ((state == ST_IDLE) && init_end),
      .g     (arb_g),
      .valid (arb_valid)
   );

   assign sel_addr  = arb_g ? req_addr1  : req_addr0;
   assign sel_beats = arb_g ? req_beats1 : req_beats0;
   assign wm_data   = gnt   ? req_data1  : req_data0;

   // Burst = min(remaining beats, max burst, beats left in the current row)
   always_comb begin
      room = {1'b1, {COL_BITS{1'b0}}} - {1'b0, cur_addr[COL_BITS-1:0]};
      bmin = CW'(remain);
      if (CW'(WBURST_LEN) < bmin) bmin = CW'(WBURST_LEN);
      if (CW'(room) < bmin)       bmin = CW'(room);
      burst_c = BURST_W'(bmin);
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= next;
   end

   always_comb begin
      next        = state;
      next_gnt    = gnt;
      req_ready   = '0;
      req_data_en = '0;
      wm_trig     = 1'b0;
      case (state)
         ST_IDLE: if (arb_valid) begin
            req_ready[arb_g] = 1'b1;
            next_gnt         = arb_g;
            next             = (sel_beats == '0) ? ST_FIN : ST_CALC;
         end
         ST_CALC:  next = ST_ISSUE;
         ST_ISSUE: if (wm_ready) begin
            wm_trig = 1'b1;
            next    = ST_WAIT;
         end
         ST_WAIT: begin
            req_data_en[gnt] = wm_data_en;
            if (wm_done) next = (remain == LEN_WIDTH'(burst)) ? ST_FIN : ST_CALC;
         end
         ST_FIN:  next = ST_IDLE;
         default: next = ST_IDLE;
      endcase
   end

   // Request latch, burst bookkeeping and the done pulse (high for the FIN cycle)
   always_ff @(posedge clk) begin
      if (!rstn) begin
         gnt      <= 1'b0;
         cur_addr <= '0;
         remain   <= '0;
         burst    <= '0;
         wm_addr  <= '0;
         wm_len   <= '0;
         req_done <= '0;
      end else begin
         gnt      <= next_gnt;
         req_done <= '0;
         if (next == ST_FIN) req_done[next_gnt] <= 1'b1;
         case (state)
            ST_IDLE: if (arb_valid) begin
               cur_addr <= sel_addr;
               remain   <= sel_beats;
            end
            ST_CALC: begin
               burst   <= burst_c;
               wm_addr <= cur_addr;
               wm_len  <= 8'(burst_c - BURST_W'(1));
            end
            ST_WAIT: if (wm_done) begin
               cur_addr <= cur_addr + ADDR_WIDTH'(burst);
               remain   <= remain - LEN_WIDTH'(burst);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Directed bench for axi_wr_scheduler with a hand-driven write-master responder.
module tb_axi_wr_scheduler;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        init_end = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [26:0] req_addr0 = '0, req_addr1 = '0;
   logic [15:0] req_beats0 = '0, req_beats1 = '0;
   logic [1:0]  req_ready, req_data_en, req_done;
   logic [15:0] req_data0 = 16'h1111, req_data1 = 16'h2222;
   logic        wm_trig;
   logic [26:0] wm_addr;
   logic [7:0]  wm_len;
   logic [15:0] wm_data;
   logic        wm_ready = 1'b1, wm_data_en = 1'b0, wm_done = 1'b0;

   int ntot = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   axi_wr_scheduler dut (
      .clk(clk), .rstn(rstn), .init_end(init_end), .req_valid(req_valid),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_beats0(req_beats0), .req_beats1(req_beats1),
      .req_ready(req_ready), .req_data0(req_data0), .req_data1(req_data1),
      .req_data_en(req_data_en), .req_done(req_done),
      .wm_trig(wm_trig), .wm_addr(wm_addr), .wm_len(wm_len), .wm_data(wm_data),
      .wm_ready(wm_ready), .wm_data_en(wm_data_en), .wm_done(wm_done)
   );

   // Write-master stand-in: wait for a trigger, feed len+1 beats, then pulse done.
   task automatic serve_burst(input logic p, output logic [26:0] a, output logic [7:0] l,
                              output int cyc, output int en_cnt, output int bad);
      logic [15:0] exp_d;
      exp_d = p ? 16'h2222 : 16'h1111;
      a = '0; l = '0; cyc = 0; en_cnt = 0; bad = 0;
      #1;
      while (!wm_trig && cyc < 40) begin
         @(posedge clk); @(negedge clk); #1; cyc++;
      end
      if (!wm_trig) begin bad++; return; end
      a = wm_addr; l = wm_len;
      @(posedge clk);
      for (int i = 0; i <= int'(l); i++) begin
         @(negedge clk); wm_data_en = 1'b1; #1;
         if (req_data_en[p])  en_cnt++;
         if (req_data_en[~p]) bad++;
         if (wm_trig)         bad++;
         if (wm_data !== exp_d) bad++;
         @(posedge clk);
      end
      @(negedge clk); wm_data_en = 1'b0; wm_done = 1'b1; #1;
      if (wm_trig) bad++;
      @(posedge clk); @(negedge clk); wm_done = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; req_valid = '0; wm_data_en = 1'b0; wm_done = 1'b0; wm_ready = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk); rstn = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      ntot++; if ({req_ready, req_data_en, req_done, wm_trig} !== 7'b0) begin nbad++; $display("FAIL reset_pulses got=%b exp=0", {req_ready, req_data_en, req_done, wm_trig}); end
      ntot++; if (wm_addr !== 27'd0 || wm_len !== 8'd0) begin nbad++; $display("FAIL reset_wm got addr=%h len=%h exp 0/0", wm_addr, wm_len); end
      ntot++; if (wm_data !== 16'h1111) begin nbad++; $display("FAIL reset_wm_data got=%h exp=1111", wm_data); end
      rstn = 1'b1; init_end = 1'b0; req_valid = 2'b01; req_beats0 = 16'd4;
      @(posedge clk); @(negedge clk); #1;
      ntot++; if (req_ready !== 2'b00) begin nbad++; $display("FAIL no_init_grant got=%b exp=00", req_ready); end
      req_valid = 2'b00; init_end = 1'b1;
   endtask

   task automatic test_row_aligned();
      logic [26:0] a; logic [7:0] l; int cyc, en, bad, tot_en;
      logic [26:0] ea [3] = '{27'h000, 27'h008, 27'h010};
      logic [7:0]  el [3] = '{8'd7, 8'd7, 8'd3};
      tot_en = 0;
      @(negedge clk); req_valid = 2'b01; req_addr0 = 27'h000; req_beats0 = 16'd20; #1;
      ntot++; if (req_ready !== 2'b01) begin nbad++; $display("FAIL aligned_ready got=%b exp=01", req_ready); end
      @(posedge clk); @(negedge clk); req_valid = 2'b00;
      for (int b = 0; b < 3; b++) begin
         serve_burst(1'b0, a, l, cyc, en, bad);
         tot_en += en;
         ntot++; if (a !== ea[b] || l !== el[b] || cyc != 1 || bad != 0) begin nbad++; $display("FAIL aligned_burst%0d got a=%h l=%0d cyc=%0d bad=%0d exp a=%h l=%0d cyc=1", b, a, l, cyc, bad, ea[b], el[b]); end
         ntot++; if (req_done !== ((b == 2) ? 2'b01 : 2'b00)) begin nbad++; $display("FAIL aligned_done%0d got=%b", b, req_done); end
      end
      ntot++; if (tot_en != 20) begin nbad++; $display("FAIL aligned_data_en got=%0d exp=20", tot_en); end
      @(negedge clk);
      ntot++; if (req_done !== 2'b00) begin nbad++; $display("FAIL aligned_done_pulse got=%b exp=00", req_done); end
   endtask

   task automatic test_row_cross();
      logic [26:0] a; logic [7:0] l; int cyc, en, bad;
      @(negedge clk); req_valid = 2'b10; req_addr1 = 27'h3FD; req_beats1 = 16'd8; #1;
      ntot++; if (req_ready !== 2'b10) begin nbad++; $display("FAIL cross_ready got=%b exp=10", req_ready); end
      @(posedge clk); @(negedge clk); req_valid = 2'b00;
      serve_burst(1'b1, a, l, cyc, en, bad);
      ntot++; if (a !== 27'h3FD || l !== 8'd2 || en != 3 || bad != 0) begin nbad++; $display("FAIL cross_b0 got a=%h l=%0d en=%0d bad=%0d exp a=3fd l=2 en=3", a, l, en, bad); end
      serve_burst(1'b1, a, l, cyc, en, bad);
      ntot++; if (a !== 27'h400 || l !== 8'd4 || en != 5 || bad != 0) begin nbad++; $display("FAIL cross_b1 got a=%h l=%0d en=%0d bad=%0d exp a=400 l=4 en=5", a, l, en, bad); end
      ntot++; if (req_done !== 2'b10) begin nbad++; $display("FAIL cross_done got=%b exp=10", req_done); end
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      logic [26:0] a; logic [7:0] l; int cyc, en, bad;
      logic [1:0]  exp_r [3] = '{2'b01, 2'b10, 2'b01};
      do_reset();
      req_addr0 = 27'h100; req_beats0 = 16'd2; req_addr1 = 27'h200; req_beats1 = 16'd2;
      req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         ntot++; if (req_ready !== exp_r[k]) begin nbad++; $display("FAIL simul_grant%0d got=%b exp=%b", k, req_ready, exp_r[k]); end
         @(posedge clk); @(negedge clk);
         if (k == 2) req_valid = 2'b00;
         serve_burst(exp_r[k][1], a, l, cyc, en, bad);
         ntot++; if (a !== (exp_r[k][1] ? 27'h200 : 27'h100) || en != 2 || bad != 0) begin nbad++; $display("FAIL simul_burst%0d got a=%h en=%0d bad=%0d", k, a, en, bad); end
         ntot++; if (req_done !== exp_r[k]) begin nbad++; $display("FAIL simul_done%0d got=%b exp=%b", k, req_done, exp_r[k]); end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_len();
      @(negedge clk); req_valid = 2'b01; req_addr0 = 27'h5; req_beats0 = 16'd0; #1;
      ntot++; if (req_ready !== 2'b01) begin nbad++; $display("FAIL zero_ready got=%b exp=01", req_ready); end
      @(posedge clk); @(negedge clk); req_valid = 2'b00; #1;
      ntot++; if (req_done !== 2'b01 || wm_trig !== 1'b0) begin nbad++; $display("FAIL zero_done got done=%b trig=%b exp 01/0", req_done, wm_trig); end
      @(posedge clk); @(negedge clk); #1;
      ntot++; if (req_done !== 2'b00 || wm_trig !== 1'b0) begin nbad++; $display("FAIL zero_after got done=%b trig=%b exp 00/0", req_done, wm_trig); end
   endtask

   task automatic test_backpressure();
      logic [26:0] a; logic [7:0] l; int cyc, en, bad, trig_seen, unstable;
      trig_seen = 0; unstable = 0;
      @(negedge clk); wm_ready = 1'b0; req_valid = 2'b01; req_addr0 = 27'h20; req_beats0 = 16'd4;
      @(posedge clk); @(negedge clk); req_valid = 2'b00;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); @(negedge clk); #1;
         if (wm_trig) trig_seen++;
         if (wm_addr !== 27'h20 || wm_len !== 8'd3) unstable++;
      end
      ntot++; if (trig_seen != 0) begin nbad++; $display("FAIL bp_trig_held got=%0d exp=0", trig_seen); end
      ntot++; if (unstable != 0) begin nbad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
      wm_ready = 1'b1;
      serve_burst(1'b0, a, l, cyc, en, bad);
      ntot++; if (cyc != 0 || a !== 27'h20 || l !== 8'd3 || en != 4 || bad != 0) begin nbad++; $display("FAIL bp_burst got cyc=%0d a=%h l=%0d en=%0d bad=%0d exp 0/20/3/4/0", cyc, a, l, en, bad); end
      ntot++; if (req_done !== 2'b01) begin nbad++; $display("FAIL bp_done got=%b exp=01", req_done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [26:0] a; logic [7:0] l; int cyc, en, bad, tmo;
      @(negedge clk); req_valid = 2'b10; req_addr1 = 27'h50; req_beats1 = 16'd16;
      @(posedge clk); @(negedge clk); req_valid = 2'b00;
      tmo = 0;
      while (!wm_trig && tmo < 20) begin @(posedge clk); @(negedge clk); #1; tmo++; end
      ntot++; if (wm_trig !== 1'b1) begin nbad++; $display("FAIL mid_trig got=%b exp=1", wm_trig); end
      @(posedge clk);
      repeat (2) begin @(negedge clk); wm_data_en = 1'b1; @(posedge clk); end
      @(negedge clk); wm_data_en = 1'b0; rstn = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      ntot++; if ({req_ready, req_data_en, req_done, wm_trig} !== 7'b0 || wm_addr !== 27'd0 || wm_len !== 8'd0 || wm_data !== 16'h1111) begin nbad++; $display("FAIL mid_reset got pulses=%b addr=%h len=%h data=%h", {req_ready, req_data_en, req_done, wm_trig}, wm_addr, wm_len, wm_data); end
      rstn = 1'b1;
      @(negedge clk); req_valid = 2'b01; req_addr0 = 27'h3F8; req_beats0 = 16'd10;
      @(posedge clk); @(negedge clk); req_valid = 2'b00;
      serve_burst(1'b0, a, l, cyc, en, bad);
      ntot++; if (a !== 27'h3F8 || l !== 8'd7 || en != 8 || bad != 0) begin nbad++; $display("FAIL exact_fit got a=%h l=%0d en=%0d bad=%0d exp 3f8/7/8", a, l, en, bad); end
      serve_burst(1'b0, a, l, cyc, en, bad);
      ntot++; if (a !== 27'h400 || l !== 8'd1 || en != 2 || bad != 0) begin nbad++; $display("FAIL next_row got a=%h l=%0d en=%0d bad=%0d exp 400/1/2", a, l, en, bad); end
      ntot++; if (req_done !== 2'b01) begin nbad++; $display("FAIL mid_new_done got=%b exp=01", req_done); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_row_aligned();
      test_row_cross();
      test_simultaneous();
      test_zero_len();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
